mccoy_ctrl_seq: RTL

Multi-cycle control sequencer for the McCoy core. It supersedes the purely combinational opcode decode. It accepts an instruction opcode through a valid/ready handshake, registers the decoded control word, and presents it for exactly one EXEC cycle. In that cycle it resolves branch/jump versus PC increment, and it traps illegal opcodes into a HALT state.

---
 rtl/mccoy_ctrl_seq_if.sv | 11 +
 rtl/mccoy_ctrl_seq.sv | 107 ++++++++++
 2 files changed

// File: rtl/mccoy_ctrl_seq_if.sv
// rtl/mccoy_ctrl_seq_if.sv - opcode valid/ready handshake into the McCoy sequencer
interface mccoy_ctrl_seq_if #(
    parameter int OP_W = 3
);
    logic            instr_valid;
    logic            instr_ready;
    logic [OP_W-1:0] instr_op;

    modport master (output instr_valid, output instr_op, input instr_ready);
    modport slave  (input instr_valid, input instr_op, output instr_ready);
endinterface

// File: rtl/mccoy_ctrl_seq.sv
// rtl/mccoy_ctrl_seq.sv - McCoy multi-cycle control sequencer
// Optional retired-instruction counter enabled by MCCOY_INSTR_COUNT_EN.
module mccoy_ctrl_seq #(
    parameter int OP_W         = 3,
    parameter bit ILLEGAL_HALT = 1'b1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    mccoy_ctrl_seq_if.slave  instr,
    input  logic             x8_zero,
    input  logic             resume,
    output logic             ctrl_valid,
    output logic             bez,
    output logic             ja,
    output logic             op1,
    output logic             op2,
    output logic             writeReg,
    output logic             writex8,
    output logic [1:0]       x8Sel,
    output logic             branch_taken,
    output logic             pc_inc,
    output logic             halted
`ifdef MCCOY_INSTR_COUNT_EN
    ,
    output logic [CNT_W-1:0] instr_count
`endif
);
    typedef enum logic [1:0] {IDLE, DECODE, EXEC, HALT} state_t;

    state_t          state, state_nxt;
    logic [OP_W-1:0] op_q;
    // control word layout: {bez, ja, op1, op2, writeReg, writex8, x8Sel[1:0]}
    logic [7:0]      cw_q, cw_dec;
    logic            op_legal, in_exec, taken;

    assign op_legal = (op_q < OP_W'(7));

    always_comb begin
        cw_dec = '0;
        case (op_q)
            OP_W'(0): cw_dec = 8'b0000_0101;
            OP_W'(1): cw_dec = 8'b0010_0110;
            OP_W'(2): cw_dec = 8'b1001_0000;
            OP_W'(3): cw_dec = 8'b0000_0100;
            OP_W'(4): cw_dec = 8'b0000_1000;
            OP_W'(5): cw_dec = 8'b0111_0000;
            OP_W'(6): cw_dec = 8'b0010_0111;
            default:  cw_dec = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            op_q  <= '0;
            cw_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && instr.instr_valid)
                op_q <= instr.instr_op;
            if (state == DECODE)
                cw_q <= cw_dec;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (instr.instr_valid) state_nxt = DECODE;
            DECODE:  state_nxt = (!op_legal && ILLEGAL_HALT) ? HALT : EXEC;
            EXEC:    state_nxt = IDLE;
            HALT:    if (resume) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Reset masks every output in the reset cycle, including an in-flight EXEC.
    assign in_exec           = (state == EXEC) && !reset;
    assign instr.instr_ready = (state == IDLE) && !reset;
    assign halted            = (state == HALT) && !reset;

    assign ctrl_valid   = in_exec;
    assign bez          = in_exec & cw_q[7];
    assign ja           = in_exec & cw_q[6];
    assign op1          = in_exec & cw_q[5];
    assign op2          = in_exec & cw_q[4];
    assign writeReg     = in_exec & cw_q[3];
    assign writex8      = in_exec & cw_q[2];
    assign x8Sel        = in_exec ? cw_q[1:0] : 2'b00;
    assign taken        = cw_q[6] | (cw_q[7] & x8_zero);
    assign branch_taken = in_exec & taken;
    assign pc_inc       = in_exec & ~taken;

`ifdef MCCOY_INSTR_COUNT_EN
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset)
            count_q <= '0;
        else if (in_exec)
            count_q <= count_q + CNT_W'(1);
    end

    assign instr_count = count_q;
`endif
endmodule
